// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch, decode, execute, memory and writeback, driving the datapath
// enables/selects and the 2-bit alu_op consumed by Alu_ctrl.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   opcode            instr[31:26] from the instruction register
//   zero              ALU zero flag, qualifies pc_write_cond into pc_en
//   mem_ready         memory handshake (only with MULTI_CTRL_STALL_EN)
//   pc_write .. pc_src  datapath controls, decoded from the state register
//   pc_en             pc_write | (pc_write_cond & zero), combinational
//   illegal_op        high during DECODE when the opcode is undefined
//   state_o           current state, for debug
//
// Build option: MULTI_CTRL_STALL_EN makes FETCH, MEMRD and MEMWR wait for
// mem_ready; PC and IR load only on the ready cycle of FETCH.
module multicycle_ctrl #(
    parameter int unsigned OP_W = 6,
    parameter int unsigned ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_o
);

    typedef enum logic [ST_W-1:0] {
        S_RST    = ST_W'(0),
        S_FETCH  = ST_W'(1),
        S_DECODE = ST_W'(2),
        S_MEMADR = ST_W'(3),
        S_MEMRD  = ST_W'(4),
        S_MEMWB  = ST_W'(5),
        S_MEMWR  = ST_W'(6),
        S_EXEC   = ST_W'(7),
        S_ALUWB  = ST_W'(8),
        S_BRANCH = ST_W'(9),
        S_ADDIEX = ST_W'(10),
        S_ADDIWB = ST_W'(11),
        S_JUMP   = ST_W'(12)
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    state_t state, state_next;
    logic   ready;

`ifdef MULTI_CTRL_STALL_EN
    assign ready = mem_ready;
`else
    // Handshake ignored: memory always completes in one cycle.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready            = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_RST;
        else     state <= state_next;
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next    = S_RST;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        illegal_op    = 1'b0;
        case (state)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                // PC/IR load only once, on the cycle the fetch completes.
                pc_write   = ready;
                ir_write   = ready;
                state_next = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                state_next = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                state_next = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                state_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                state_next = S_FETCH;
            end
            default: state_next = S_RST;
        endcase
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign state_o = state;

endmodule
